// File: rtl/q1_scan_reader_pkg.sv
// Shared state encoding, strobe levels and parameter defaults for the Q1 scan reader.
package q1_scan_reader_pkg;

  localparam int ADDR_W_DEFAULT     = 15;
  localparam int FIFO_DEPTH_DEFAULT = 4;

  localparam logic STRB_IDLE = 1'b0;
  localparam logic STRB_READ = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

endpackage

// File: rtl/q1_scan_reader_byte_fifo.sv
// Small synchronous show-ahead FIFO with flush; DEPTH must be a power of two.
module q1_scan_reader_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine as long as the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/q1_scan_reader.sv
// Sequential reader on the Q1 memory port: fetches length bytes from start_addr and
// streams them through a small FIFO to a valid/ready consumer.
module q1_scan_reader
  import q1_scan_reader_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              Q1_CLOCK,
  output logic [ADDR_W-1:0] Q1_ADDRESS,
  input  logic [7:0]        Q1_DATA_IN,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  scan_state_t       state;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] remaining;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              pop;
  logic [CNT_W:0]    projected;
  logic              issue;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // Occupancy after this edge; a strobe issued now lands one edge later, so it needs a free slot then.
  assign projected = {1'b0, fifo_count} + {{CNT_W{1'b0}}, Q1_CLOCK} - {{CNT_W{1'b0}}, pop};
  assign issue     = (state == ST_FETCH) && (remaining != '0) &&
                     (projected < (CNT_W+1)'(FIFO_DEPTH));

  q1_scan_reader_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (Q1_CLOCK),
    .push_data (Q1_DATA_IN),
    .pop       (pop),
    .flush     (abort),
    .head_data (out_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      Q1_CLOCK   <= STRB_IDLE;
      Q1_ADDRESS <= '0;
      next_addr  <= '0;
      remaining  <= '0;
    end else begin
      done     <= 1'b0;
      Q1_CLOCK <= STRB_IDLE;
      if (abort) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        remaining <= '0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              if (length != '0) begin
                state     <= ST_FETCH;
                busy      <= 1'b1;
                next_addr <= start_addr;
                remaining <= length;
              end else begin
                done <= 1'b1;
              end
            end
          end
          ST_FETCH: begin
            if (issue) begin
              Q1_CLOCK   <= STRB_READ;
              Q1_ADDRESS <= next_addr;
              next_addr  <= next_addr + ADDR_W'(1);
              remaining  <= remaining - ADDR_W'(1);
              if (remaining == ADDR_W'(1)) state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            // Last byte leaves only once the final strobe has landed and the FIFO pops to empty.
            if (pop && (fifo_count == CNT_W'(1)) && (Q1_CLOCK == STRB_IDLE)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_q1_scan_reader.sv
// Directed and random checks for q1_scan_reader against a byte-pattern memory model.
module tb_q1_scan_reader;

  localparam int ADDR_W = 15;

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b1;
  logic              start      = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [ADDR_W-1:0] length     = '0;
  logic              abort      = 1'b0;
  logic              out_ready  = 1'b0;
  logic              busy;
  logic              done;
  logic              q1_clock;
  logic [ADDR_W-1:0] q1_address;
  wire  [7:0]        q1_data;
  logic              out_valid;
  logic [7:0]        out_data;

  logic fixed_ready = 1'b0;
  logic rand_ready  = 1'b0;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [7:0]        pop_q[$];
  int                pop_cyc_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  function automatic logic [7:0] memByte(input logic [ADDR_W-1:0] a);
    return 8'(a * 8'd29) ^ {1'b0, a[14:8]};
  endfunction

  // Memory drives data only while the strobe is high.
  assign q1_data = q1_clock ? memByte(q1_address) : 8'hzz;

  q1_scan_reader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .Q1_CLOCK   (q1_clock),
    .Q1_ADDRESS (q1_address),
    .Q1_DATA_IN (q1_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
  end

  // Logs strobes, consumed bytes and done pulses mid-cycle, when everything is settled.
  always @(negedge clk) begin
    if (reset_n) begin
      if (q1_clock) addr_q.push_back(q1_address);
      if (out_valid && out_ready && !abort) begin
        pop_q.push_back(out_data);
        pop_cyc_q.push_back(cyc);
      end
      if (done) done_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] n);
    start      = 1'b1;
    start_addr = a;
    length     = n;
    tick();
    start      = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    tick();
  endtask

  function automatic int badBytes(input int base, input logic [ADDR_W-1:0] a, input int n);
    int bad;
    logic [ADDR_W-1:0] ea;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      ea = a + ADDR_W'(i);
      if (base + i >= pop_q.size()) bad++;
      else if (pop_q[base + i] !== memByte(ea)) bad++;
    end
    return bad;
  endfunction

  task automatic runChecked(input string tag, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] n);
    int pb;
    int db;
    pb = pop_q.size();
    db = done_cnt;
    applyStimulus(a, n);
    waitIdle(tag, 400);
    checkOutput({tag, "_count"}, pop_q.size() - pb, 32'(n));
    checkOutput({tag, "_bytes"}, badBytes(pb, a, int'(n)), 0);
    checkOutput({tag, "_done"}, done_cnt - db, 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},  {31'd0, busy}, 0);
    checkOutput({tag, "_done"},  {31'd0, done}, 0);
    checkOutput({tag, "_strb"},  {31'd0, q1_clock}, 0);
    checkOutput({tag, "_addr"},  {17'd0, q1_address}, 0);
    checkOutput({tag, "_valid"}, {31'd0, out_valid}, 0);
    checkOutput({tag, "_data"},  {24'd0, out_data}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pb, ab, db, bad;
    logic [ADDR_W-1:0] exp3 [4];
    logic [ADDR_W-1:0] ra;
    logic [ADDR_W-1:0] rl;

    #1 reset_n = 1'b0;
    #1 checkResetOutputs("reset");
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Case 1: full-rate streaming.
    fixed_ready = 1'b1;
    tick();
    pb = pop_q.size();
    runChecked("t1", 15'h0010, 15'd8);
    checkOutput("t1_consec", (pop_cyc_q.size() >= pb + 8) ? pop_cyc_q[pb+7] - pop_cyc_q[pb] : -1, 7);
    checkOutput("t1_busy_after", {31'd0, busy}, 0);

    // Case 2: stalled consumer fills the FIFO, then drains.
    fixed_ready = 1'b0;
    ab = addr_q.size();
    pb = pop_q.size();
    db = done_cnt;
    applyStimulus(15'h0100, 15'd6);
    tick(12);
    checkOutput("t2_strobes_stalled", addr_q.size() - ab, 4);
    checkOutput("t2_strb_low", {31'd0, q1_clock}, 0);
    checkOutput("t2_valid_held", {31'd0, out_valid}, 1);
    checkOutput("t2_head_held", {24'd0, out_data}, {24'd0, memByte(15'h0100)});
    fixed_ready = 1'b1;
    waitIdle("t2", 100);
    checkOutput("t2_strobes_total", addr_q.size() - ab, 6);
    checkOutput("t2_count", pop_q.size() - pb, 6);
    checkOutput("t2_bytes", badBytes(pb, 15'h0100, 6), 0);
    checkOutput("t2_done", done_cnt - db, 1);

    // Case 3: address wraps past the top of memory.
    ab = addr_q.size();
    runChecked("t3", 15'h7FFE, 15'd4);
    exp3 = '{15'h7FFE, 15'h7FFF, 15'h0000, 15'h0001};
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("t3_addr%0d", i),
                  (addr_q.size() > ab + i) ? {17'd0, addr_q[ab+i]} : 32'hFFFF_FFFF, {17'd0, exp3[i]});

    // Case 4: abort with three bytes buffered and a strobe in flight.
    fixed_ready = 1'b0;
    tick();
    ab = addr_q.size();
    pb = pop_q.size();
    db = done_cnt;
    applyStimulus(15'h0200, 15'd10);
    tick(4);
    checkOutput("t4_strb_before", {31'd0, q1_clock}, 1);
    checkOutput("t4_valid_before", {31'd0, out_valid}, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t4_valid_after", {31'd0, out_valid}, 0);
    checkOutput("t4_busy_after", {31'd0, busy}, 0);
    checkOutput("t4_strb_after", {31'd0, q1_clock}, 0);
    tick(3);
    checkOutput("t4_strobes", addr_q.size() - ab, 4);
    checkOutput("t4_no_done", done_cnt - db, 0);
    checkOutput("t4_no_pop", pop_q.size() - pb, 0);
    fixed_ready = 1'b1;
    tick();
    runChecked("t4_restart", 15'h0300, 15'd5);

    // Case 5: zero-length start, then a start while busy.
    ab = addr_q.size();
    db = done_cnt;
    applyStimulus(15'h0400, 15'd0);
    checkOutput("t5_done_pulse", {31'd0, done}, 1);
    checkOutput("t5_busy0", {31'd0, busy}, 0);
    tick();
    checkOutput("t5_done_low", {31'd0, done}, 0);
    checkOutput("t5_busy1", {31'd0, busy}, 0);
    tick(2);
    checkOutput("t5_no_strobe", addr_q.size() - ab, 0);
    checkOutput("t5_done_once", done_cnt - db, 1);

    ab = addr_q.size();
    pb = pop_q.size();
    db = done_cnt;
    applyStimulus(15'h0500, 15'd6);
    tick(2);
    applyStimulus(15'h0600, 15'd3);
    waitIdle("t5b", 100);
    checkOutput("t5b_strobes", addr_q.size() - ab, 6);
    bad = 0;
    for (int i = 0; i < 6; i++)
      if (addr_q.size() <= ab + i || addr_q[ab+i] !== 15'h0500 + ADDR_W'(i)) bad++;
    checkOutput("t5b_addrs", bad, 0);
    checkOutput("t5b_bytes", badBytes(pb, 15'h0500, 6), 0);
    checkOutput("t5b_done", done_cnt - db, 1);

    // Case 6: random consumer, random transfers, then reset mid-transfer.
    rand_ready = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      ra = ADDR_W'($urandom_range(0, 32767));
      rl = ADDR_W'($urandom_range(1, 12));
      runChecked("rnd", ra, rl);
    end

    applyStimulus(15'h1234, 15'd12);
    tick(5);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs("midreset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick(2);
    checkResetOutputs("postreset");
    runChecked("after_reset", 15'h2000, 15'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
